// File: rtl/mrd_pkg.sv
// mrd_pkg: shared bank count, default widths and write-stage FSM states.
package mrd_pkg;
  localparam int NUM_BANK = 5;
  localparam int W_DATA   = 18;
  localparam int W_ADDR   = 8;
  localparam int W_CNT    = 10;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
endpackage

// File: rtl/mrd_mem_wr_if.sv
// mrd_mem_wr_if: 5-lane input vector bus and per-bank write port bus.
interface mrd_mem_wr_if import mrd_pkg::*; #(
  parameter int wDataInOut = W_DATA,
  parameter int wAddr      = W_ADDR
);
  logic                         in_valid;
  logic [2:0]                   in_bank_index [NUM_BANK];
  logic [wAddr-1:0]             in_bank_addr  [NUM_BANK];
  logic signed [wDataInOut-1:0] in_d_real     [NUM_BANK];
  logic signed [wDataInOut-1:0] in_d_imag     [NUM_BANK];
  logic                         wren          [NUM_BANK];
  logic [wAddr-1:0]             wraddr        [NUM_BANK];
  logic [2*wDataInOut-1:0]      wrdata        [NUM_BANK];
  modport master (output in_valid, in_bank_index, in_bank_addr, in_d_real, in_d_imag,
                  input  wren, wraddr, wrdata);
  modport slave  (input  in_valid, in_bank_index, in_bank_addr, in_d_real, in_d_imag,
                  output wren, wraddr, wrdata);
endinterface

// File: rtl/mrd_mem_wr_xbar.sv
// mrd_mem_wr_xbar: lane-to-bank crossbar; lowest lane wins a bank, bad or duplicate indices flag a conflict.
module mrd_mem_wr_xbar import mrd_pkg::*; #(
  parameter int wDataInOut = W_DATA,
  parameter int wAddr      = W_ADDR
) (
  input  logic [2:0]                   idx  [NUM_BANK],
  input  logic [wAddr-1:0]             addr [NUM_BANK],
  input  logic signed [wDataInOut-1:0] re   [NUM_BANK],
  input  logic signed [wDataInOut-1:0] im   [NUM_BANK],
  output logic                         en   [NUM_BANK],
  output logic [wAddr-1:0]             wa   [NUM_BANK],
  output logic [2*wDataInOut-1:0]      wd   [NUM_BANK],
  output logic                         conflict
);
  always_comb begin
    conflict = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      en[b] = 1'b0;
      wa[b] = '0;
      wd[b] = '0;
    end
    for (int k = 0; k < NUM_BANK; k++) begin
      conflict = conflict | (idx[k] >= 3'(NUM_BANK));
      for (int b = 0; b < NUM_BANK; b++) begin
        if (idx[k] == 3'(b)) begin
          conflict = conflict | en[b];
          if (!en[b]) begin
            en[b] = 1'b1;
            wa[b] = addr[k];
            wd[b] = {re[k], im[k]};
          end
        end
      end
    end
  end
endmodule

// File: rtl/mrd_mem_wr.sv
// mrd_mem_wr: registers routed 5-lane vectors into 5 bank write ports and tracks stage progress.
module mrd_mem_wr import mrd_pkg::*; #(
  parameter int wDataInOut = W_DATA,
  parameter int wAddr      = W_ADDR,
  parameter int wCnt       = W_CNT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sop,
  input  logic [wCnt-1:0] stage_len,
  input  logic [3:0]      in_exp,
  mrd_mem_wr_if.slave     bus,
  output logic            stage_done,
  output logic [3:0]      stage_exp,
  output logic [wCnt-1:0] vec_cnt,
  output logic            err_conflict,
  output logic            err_overrun
);
  state_t                  state, next;
  logic [wCnt-1:0]         len_r;
  logic                    accept, conflict;
  logic                    en [NUM_BANK];
  logic [wAddr-1:0]        xa [NUM_BANK];
  logic [2*wDataInOut-1:0] xd [NUM_BANK];
  mrd_mem_wr_xbar #(.wDataInOut(wDataInOut), .wAddr(wAddr)) u_xbar (
    .idx(bus.in_bank_index), .addr(bus.in_bank_addr), .re(bus.in_d_real), .im(bus.in_d_imag),
    .en(en), .wa(xa), .wd(xd), .conflict(conflict)
  );
  // sop accepts a same-cycle vector as the first one of the new stage
  always_comb begin
    accept = bus.in_valid && (sop ? stage_len != '0 : state == ACTIVE);
    next   = sop ? ((stage_len == '0 || (accept && stage_len == wCnt'(1))) ? DONE : ACTIVE)
           : state == DONE ? IDLE
           : (state == ACTIVE && accept && vec_cnt == len_r - wCnt'(1)) ? DONE
           : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end
  assign stage_done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r        <= '0;
      vec_cnt      <= '0;
      stage_exp    <= '0;
      err_conflict <= 1'b0;
      err_overrun  <= 1'b0;
      for (int b = 0; b < NUM_BANK; b++) begin
        bus.wren[b]   <= 1'b0;
        bus.wraddr[b] <= '0;
        bus.wrdata[b] <= '0;
      end
    end else begin
      if (sop) len_r <= stage_len;
      vec_cnt      <= sop ? wCnt'(accept) : (accept && vec_cnt != len_r) ? vec_cnt + wCnt'(1) : vec_cnt;
      if (next == DONE) stage_exp <= in_exp;
      err_conflict <= (sop ? 1'b0 : err_conflict) | (accept & conflict);
      err_overrun  <= (sop ? 1'b0 : err_overrun) | (bus.in_valid & ~accept);
      for (int b = 0; b < NUM_BANK; b++) begin
        bus.wren[b] <= accept && en[b];
        if (accept && en[b]) begin
          bus.wraddr[b] <= xa[b];
          bus.wrdata[b] <= xd[b];
        end
      end
    end
  end
endmodule

// File: tb/tb_mrd_mem_wr.sv
// tb_mrd_mem_wr: scoreboard bench for the bank write router and its stage FSM.
module tb_mrd_mem_wr;
  logic       clk = 1'b0;
  logic       rst_n, sop;
  logic [9:0] stage_len, vec_cnt;
  logic [3:0] in_exp, stage_exp;
  logic       stage_done, err_conflict, err_overrun;
  int         checks = 0, errors = 0, wr_total = 0;
  typedef struct packed {
    logic [4:0]        en;
    logic [4:0][7:0]   a;
    logic [4:0][35:0]  d;
  } exp_t;
  exp_t        q[$];
  logic [7:0]  hold_a [5];
  logic [35:0] hold_d [5];
  localparam logic [14:0] IDX_ID  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  localparam logic [14:0] IDX_REV = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] IDX_BAD = {3'd1, 3'd1, 3'd2, 3'd3, 3'd7};
  mrd_mem_wr_if bus();
  mrd_mem_wr dut (
    .clk(clk), .rst_n(rst_n), .sop(sop), .stage_len(stage_len), .in_exp(in_exp), .bus(bus),
    .stage_done(stage_done), .stage_exp(stage_exp), .vec_cnt(vec_cnt),
    .err_conflict(err_conflict), .err_overrun(err_overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one cycle of stimulus; expected bank writes go through the queue
  task automatic drive(input bit s, input bit v, input logic [14:0] ix, input logic [7:0] a0,
                       input logic signed [17:0] r0, input bit acc);
    exp_t e;
    logic [2:0] b;
    @(negedge clk);
    sop = s;
    bus.in_valid = v;
    for (int k = 0; k < 5; k++) begin
      bus.in_bank_index[k] = ix[14-3*k -: 3];
      bus.in_bank_addr[k]  = k == 0 ? a0 : 8'($urandom);
      bus.in_d_real[k]     = k == 0 ? r0 : 18'($urandom);
      bus.in_d_imag[k]     = 18'($urandom);
    end
    e.en = '0;
    if (acc)
      for (int k = 0; k < 5; k++) begin
        b = ix[14-3*k -: 3];
        if (b < 3'd5 && !e.en[b]) begin
          e.en[b]   = 1'b1;
          hold_a[b] = bus.in_bank_addr[k];
          hold_d[b] = {bus.in_d_real[k], bus.in_d_imag[k]};
        end
      end
    for (int k = 0; k < 5; k++) begin
      e.a[k] = hold_a[k];
      e.d[k] = hold_d[k];
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    sop = 1'b0;
    bus.in_valid = 1'b0;
    e = q.pop_front();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("wren%0d", k), 64'(bus.wren[k]), 64'(e.en[k]));
      check($sformatf("wraddr%0d", k), 64'(bus.wraddr[k]), 64'(e.a[k]));
      check($sformatf("wrdata%0d", k), 64'(bus.wrdata[k]), 64'(e.d[k]));
      wr_total += int'(bus.wren[k]);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_vec_cnt"}, 64'(vec_cnt), 0);
    check({tag, "_stage_done"}, 64'(stage_done), 0);
    check({tag, "_stage_exp"}, 64'(stage_exp), 0);
    check({tag, "_err_conflict"}, 64'(err_conflict), 0);
    check({tag, "_err_overrun"}, 64'(err_overrun), 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_wren%0d", tag, k), 64'(bus.wren[k]), 0);
      check($sformatf("%s_wraddr%0d", tag, k), 64'(bus.wraddr[k]), 0);
      check($sformatf("%s_wrdata%0d", tag, k), 64'(bus.wrdata[k]), 0);
    end
  endtask
  initial begin
    rst_n = 1'b0; sop = 1'b0; stage_len = '0; in_exp = '0; bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_bank_index[k] = '0; bus.in_bank_addr[k] = '0;
      bus.in_d_real[k] = '0; bus.in_d_imag[k] = '0;
      hold_a[k] = '0; hold_d[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    // three full vectors, every bank written each time
    stage_len = 10'd3; in_exp = 4'd7;
    drive(1, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("start_vec_cnt", 64'(vec_cnt), 0);
    check("start_done", 64'(stage_done), 0);
    wr_total = 0;
    drive(0, 1, IDX_ID, 8'($urandom), 18'($urandom), 1);
    check("v1_vec_cnt", 64'(vec_cnt), 1);
    drive(0, 1, IDX_ID, 8'($urandom), 18'($urandom), 1);
    check("v2_vec_cnt", 64'(vec_cnt), 2);
    check("v2_done", 64'(stage_done), 0);
    in_exp = 4'd9;
    drive(0, 1, IDX_ID, 8'($urandom), 18'($urandom), 1);
    check("v3_vec_cnt", 64'(vec_cnt), 3);
    check("v3_done", 64'(stage_done), 1);
    check("v3_stage_exp", 64'(stage_exp), 9);
    check("write_count", 64'(wr_total), 15);
    check("v3_err_conflict", 64'(err_conflict), 0);
    in_exp = 4'd2;
    drive(0, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("after_done", 64'(stage_done), 0);
    check("after_stage_exp", 64'(stage_exp), 9);
    check("after_vec_cnt", 64'(vec_cnt), 3);
    // reversed routing, vector accepted together with sop
    stage_len = 10'd2;
    drive(1, 1, IDX_REV, 8'h12, -18'sd5, 1);
    check("rev_wraddr4", 64'(bus.wraddr[4]), 64'h12);
    check("rev_real4", 64'(bus.wrdata[4][35:18]), 64'h3fffb);
    check("rev_vec_cnt", 64'(vec_cnt), 1);
    check("rev_done", 64'(stage_done), 0);
    // duplicate and out-of-range indices
    drive(0, 1, IDX_BAD, 8'($urandom), 18'($urandom), 1);
    check("bad_err_conflict", 64'(err_conflict), 1);
    check("bad_vec_cnt", 64'(vec_cnt), 2);
    check("bad_done", 64'(stage_done), 1);
    check("bad_err_overrun", 64'(err_overrun), 0);
    // valid while DONE, then while IDLE
    drive(0, 1, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("done_overrun", 64'(err_overrun), 1);
    check("done_conflict_sticky", 64'(err_conflict), 1);
    drive(0, 1, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("idle_overrun", 64'(err_overrun), 1);
    check("idle_vec_cnt", 64'(vec_cnt), 2);
    stage_len = 10'd4;
    drive(1, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("sop_clr_overrun", 64'(err_overrun), 0);
    check("sop_clr_conflict", 64'(err_conflict), 0);
    check("sop_clr_vec_cnt", 64'(vec_cnt), 0);
    // reset in the middle of a stage
    drive(0, 1, IDX_REV, 8'($urandom), 18'($urandom), 1);
    drive(0, 1, IDX_ID, 8'($urandom), 18'($urandom), 1);
    check("mid_vec_cnt", 64'(vec_cnt), 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    for (int k = 0; k < 5; k++) begin
      hold_a[k] = '0; hold_d[k] = '0;
    end
    @(posedge clk);
    #1;
    check("rst_no_done", 64'(stage_done), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_no_done", 64'(stage_done), 0);
    stage_len = 10'd1;
    drive(1, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("len1_done_early", 64'(stage_done), 0);
    drive(0, 1, IDX_REV, 8'($urandom), 18'($urandom), 1);
    check("len1_vec_cnt", 64'(vec_cnt), 1);
    check("len1_done", 64'(stage_done), 1);
    drive(0, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("len1_done_gone", 64'(stage_done), 0);
    // sop with a vector and stage_len=1 completes at once
    drive(1, 1, IDX_ID, 8'($urandom), 18'($urandom), 1);
    check("sopv_vec_cnt", 64'(vec_cnt), 1);
    check("sopv_done", 64'(stage_done), 1);
    drive(0, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    // empty stage
    stage_len = 10'd0; in_exp = 4'd5;
    drive(1, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("len0_done", 64'(stage_done), 1);
    check("len0_vec_cnt", 64'(vec_cnt), 0);
    check("len0_stage_exp", 64'(stage_exp), 5);
    drive(0, 0, IDX_ID, 8'($urandom), 18'($urandom), 0);
    check("len0_done_gone", 64'(stage_done), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mrd_mem_wr.md
MRD_MEM_WR -- requirements
Module: mrd_mem_wr

Interface
REQ-001 SHALL have parameter wDataInOut, default 18, meaning the signed width of each real/imag sample.
REQ-002 SHALL have parameter wAddr, default 8, meaning the bank address width.
REQ-003 SHALL have parameter wCnt, default 10, meaning the vector-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sop  input  1  stage start pulse.
REQ-007 SHALL have port stage_len  input  wCnt  number of 5-point vectors expected in the stage; sampled on sop.
REQ-008 SHALL have port in_valid  input  1  the 5-lane input vector is valid.
REQ-009 SHALL have port in_bank_index[0:4]  input  3 each  target bank per lane.
REQ-010 SHALL have port in_bank_addr[0:4]  input  wAddr each  target address per lane.
REQ-011 SHALL have port in_d_real[0:4], in_d_imag[0:4]  input  wDataInOut each  signed twiddled samples.
REQ-012 SHALL have port in_exp  input  4  current block exponent.
REQ-013 SHALL have port wren[0:4]  output  1 each  per-bank write enable.
REQ-014 SHALL have port wraddr[0:4]  output  wAddr each  per-bank write address.
REQ-015 SHALL have port wrdata[0:4]  output  2*wDataInOut each  {real, imag} per bank.
REQ-016 SHALL have port stage_done  output  1  one-cycle pulse at stage completion.
REQ-017 SHALL have port stage_exp  output  4  in_exp latched at completion.
REQ-018 SHALL have port vec_cnt  output  wCnt  vectors accepted in the current stage.
REQ-019 SHALL have port err_conflict  output  1  sticky bank-collision or out-of-range flag.
REQ-020 SHALL have port err_overrun  output  1  sticky flag for valid outside an active stage.

Function
REQ-021 SHALL route lane k to bank in_bank_index[k]; wren/wraddr/wrdata SHALL be registered, 1-cycle latency from in_valid.
REQ-022 Banks targeted by no accepted lane SHALL have wren=0; their wraddr/wrdata SHALL hold previous values.
REQ-023 A lane with index>4 SHALL be dropped; duplicate indices: lowest lane number wins; either case sets err_conflict.
REQ-024 SHALL have FSM states IDLE, ACTIVE, DONE.
REQ-025 IDLE→ACTIVE on sop with stage_len≠0; IDLE→DONE on sop with stage_len=0.
REQ-026 ACTIVE: each in_valid increments vec_cnt; valid while vec_cnt=stage_len-1 → DONE.
REQ-027 DONE SHALL last exactly one cycle, then go to IDLE; stage_done=1 during DONE; stage_exp SHALL be loaded on entry to DONE.
REQ-028 sop in any state SHALL restart: vec_cnt cleared, stage_len resampled, errors cleared.
REQ-029 sop with in_valid in the same cycle: the vector SHALL be accepted as the first vector (vec_cnt becomes 1).
REQ-030 in_valid in IDLE or DONE (without sop): no write, err_overrun=1.
REQ-031 vec_cnt SHALL never wrap; it saturates at stage_len.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, and drive wren=0, wraddr=0, wrdata=0, vec_cnt=0, stage_done=0, stage_exp=0, err_conflict=0, err_overrun=0.
REQ-033 Reset mid-stage SHALL abandon the stage without issuing a stage_done pulse.

Structure
REQ-034 mrd_pkg SHALL hold NUM_BANK=5, the default widths, and the FSM state enum.
REQ-035 The 5×5 routing crossbar SHALL be one sub-module, mrd_mem_wr_xbar (combinational, priority by lane).

Verification
REQ-036 sop, stage_len=3, 3 valid vectors with indices {0,1,2,3,4} → 15 writes, vec_cnt=3, stage_done one cycle after the last write, stage_exp=in_exp.
REQ-037 indices {4,3,2,1,0}, lane0 addr=8'h12, real=-5 → wren[4]=1, wraddr[4]=8'h12, wrdata[4][35:18]=-5, one cycle later.
REQ-038 indices {1,1,2,3,7} → bank1 gets lane0 data; lane1 and lane4 dropped; wren[0]=0; err_conflict=1 until next sop.
REQ-039 in_valid while IDLE → all wren=0, err_overrun=1; next sop clears it.
REQ-040 stage_len=4, rst_n low after 2 vectors → all outputs zero immediately, no stage_done; a new sop with stage_len=1 and one vector → stage_done.
REQ-041 sop with in_valid, stage_len=1 → the vector is written, vec_cnt=1, DONE the next cycle.
